// File: rtl/iccm_loader_pkg.sv
// iccm_loader_pkg
//   Shared types and constants for the ICCM boot loader.
//   state_e   : loader FSM states
//   HDR_BYTES : number of length-header bytes on the stream
//   WE_ALL    : full-word byte write enable
package iccm_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    localparam int         HDR_BYTES = 2;
    localparam logic [3:0] WE_ALL    = 4'hF;

    // States in which a load is in flight and the loader owns the ICCM port.
    function automatic logic is_busy(state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) ||
               (s == ST_WRITE)  || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/iccm_loader_if.sv
// iccm_loader_if
//   Byte stream and ICCM write port of the boot loader.
//   rx_data_i/rx_valid_i/rx_ready_o : valid/ready byte stream into the loader
//   mem_en_o/mem_we_o/mem_addr_o/mem_di_o : ICCM write port out of the loader
//   modport slave  : the loader
//   modport master : the stream source / memory-side observer
interface iccm_loader_if #(
    parameter int ADDR_W = 8
) ();

    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_di_o;

    modport slave (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_di_o
    );

    modport master (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_di_o
    );

endinterface

// File: rtl/iccm_word_packer.sv
// iccm_word_packer
//   Packs a byte stream little-endian into 32-bit words.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : drop any partial word (new load)
//   byte_valid_i   : byte_i is accepted this cycle
//   byte_i         : stream byte
//   word_valid_o   : the accepted byte completes a word
//   word_o         : assembled word, valid with word_valid_o
module iccm_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    // Only the three earlier bytes need storage; the fourth is taken straight
    // from the input so the word is available in the cycle it completes.
    logic [23:0] shift_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'h0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/iccm_loader.sv
// iccm_loader
//   Boot-time ICCM writer. Receives a length-prefixed (16-bit LE word count)
//   byte stream, packs it into 32-bit LE words, writes them to ICCM word
//   addresses 0.. and holds the core in reset until the image is complete.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : begin a load (honoured in IDLE, DONE, ERR)
//   bus            : byte stream in / ICCM write port out (iccm_loader_if.slave)
//   busy_o         : load in progress, selects the loader on the ICCM mux
//   done_o, err_o  : image loaded / load aborted
//   core_rst_no    : active-low core reset, released only in DONE
//   words_o        : words written so far
//   Optional build macro ICCM_LOADER_CSUM_EN: a trailing XOR checksum byte
//   must match the data bytes before the core is released.
//
//   state    | meaning
//   IDLE     | after reset, waiting for start_i
//   LEN_LO   | waiting for word-count low byte
//   LEN_HI   | waiting for word-count high byte, then range check
//   DATA     | collecting the four bytes of a word
//   WRITE    | one-cycle ICCM write of the assembled word
//   CSUM     | waiting for the checksum byte (checksum builds only)
//   DONE     | image loaded, core released
//   ERR      | load aborted, core held in reset
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    iccm_loader_if.slave     bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             core_rst_no,
    output logic [LEN_W-1:0] words_o
);

    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  words_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_di_q;

    logic              rx_ready;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic              xfer;
    logic              start_ok;
    logic [LEN_W-1:0]  len_full;
    logic              word_valid;
    logic [31:0]       word;

`ifdef ICCM_LOADER_CSUM_EN
    logic [7:0]        csum_q;
`endif

    assign xfer     = bus.rx_valid_i && rx_ready;
    assign start_ok = start_i &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign len_full = LEN_W'({bus.rx_data_i, len_lo_q});

    iccm_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (start_ok),
        .byte_valid_i (xfer && (state_q == ST_DATA)),
        .byte_i       (bus.rx_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 4'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                rx_ready = 1'b1;
                if (xfer) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    if (len_full == '0)
                        state_d = ST_DONE;
                    else if ({1'b0, len_full} > MAX_WORDS)
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_en = 1'b1;
                mem_we = WE_ALL;
                if (words_q + LEN_W'(1) == len_q) begin
`ifdef ICCM_LOADER_CSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
`ifdef ICCM_LOADER_CSUM_EN
                rx_ready = 1'b1;
                if (xfer) state_d = (bus.rx_data_i == csum_q) ? ST_DONE : ST_ERR;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE, ST_ERR: begin
                if (start_i) state_d = ST_LEN_LO;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= 8'h0;
            len_q      <= '0;
            words_q    <= '0;
            mem_addr_q <= '0;
            mem_di_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (start_ok)
                words_q <= '0;
            if (xfer && (state_q == ST_LEN_LO))
                len_lo_q <= bus.rx_data_i;
            if (xfer && (state_q == ST_LEN_HI))
                len_q <= len_full;
            // Address/data are latched as the word completes so they are
            // stable through WRITE and hold afterwards.
            if (word_valid) begin
                mem_addr_q <= words_q[ADDR_W-1:0];
                mem_di_q   <= word;
            end
            if (state_q == ST_WRITE)
                words_q <= words_q + LEN_W'(1);
        end
    end

`ifdef ICCM_LOADER_CSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok)
            csum_q <= 8'h0;
        else if (xfer && (state_q == ST_DATA))
            csum_q <= csum_q ^ bus.rx_data_i;
    end
`endif

    assign bus.rx_ready_o = rx_ready;
    assign bus.mem_en_o   = mem_en;
    assign bus.mem_we_o   = mem_we;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_di_o   = mem_di_q;

    assign busy_o      = is_busy(state_q);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERR);
    assign core_rst_no = (state_q == ST_DONE);
    assign words_o     = words_q;

endmodule

// File: doc/iccm_loader.md
Name: iccm_loader

Overview:
- Boot-time writer for the instruction memory: the write-side counterpart of the core's read-only fetch port on the 32-bit DFFRAM ICCM.
- Receives a length-prefixed byte stream over a valid/ready handshake (from a UART RX or debug bridge).
- Packs bytes little-endian into 32-bit words, writes them to consecutive ICCM word addresses from 0, and holds the core in reset until the image is complete.
- Sits beside rv_top; shares the ICCM port through a mux selected by busy_o.

Parameters:
ADDR_W, 8, ICCM word-address width; the ICCM depth is 2**ADDR_W words.
LEN_W, 16, width of the word-count header; fixed at 2 header bytes.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  one-cycle pulse that begins a load. Acted on only in IDLE, DONE or ERR.
rx_data_i  in  8  stream byte.
rx_valid_i  in  1  stream byte valid.
rx_ready_o  out  1  loader accepts a byte this cycle.
mem_en_o  out  1  ICCM enable.
mem_we_o  out  4  ICCM byte write enables.
mem_addr_o  out  ADDR_W  ICCM word address.
mem_di_o  out  32  ICCM write data.
busy_o  out  1  load in progress; selects the loader on the ICCM mux.
done_o  out  1  image loaded.
err_o  out  1  load aborted.
core_rst_no  out  1  active-low reset to rv_top; 0 holds the core in reset.
words_o  out  LEN_W  words written so far.

Behaviour:
- Byte transfer: a byte is transferred when rx_valid_i && rx_ready_o. rx_data_i is sampled only on a transfer.
- rx_ready_o is 1 only in LEN_LO, LEN_HI and DATA.
- Reset values: rx_ready_o=0, mem_en_o=0, mem_we_o=4'h0, mem_addr_o=0, mem_di_o=0, busy_o=0, done_o=0, err_o=0, core_rst_no=0, words_o=0. State is IDLE.
- IDLE: on start_i go to LEN_LO; busy_o=1 from the next cycle.
- LEN_LO: on transfer, len[7:0]=byte; go to LEN_HI.
- LEN_HI: on transfer, len[15:8]=byte, then:
  - len==0 -> DONE.
  - len > 2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA: the byte counter (0..3) places each byte little-endian (byte k -> bits 8k+7:8k). The 4th transfer goes to WRITE.
- WRITE (exactly one cycle):
  - Drive mem_en_o=1, mem_we_o=4'hF, mem_addr_o=word index, mem_di_o=assembled word.
  - Increment words_o.
  - If words_o+1==len go to DONE (or CSUM when the option is enabled); else return to DATA.
  - Throughput is 4 bytes per 5 cycles maximum.
- mem_en_o and mem_we_o are 0 in every state except WRITE. mem_addr_o and mem_di_o hold their last values.
- DONE:
  - done_o=1, busy_o=0, core_rst_no=1.
  - core_rst_no rises on the first DONE cycle, i.e. the cycle after the final WRITE.
  - Stays in DONE until start_i or rst_i.
- ERR: err_o=1, busy_o=0, core_rst_no=0. Stays in ERR until start_i or rst_i.
- start_i from DONE or ERR:
  - Next cycle: core_rst_no=0, done_o=0, err_o=0, words_o=0.
  - State goes to LEN_LO.
- start_i in any busy state is ignored.
- Address never wraps; the length check guarantees the index stays below 2**ADDR_W. len==2**ADDR_W is legal and fills the whole ICCM.
- rx_valid_i gaps stall the FSM with no timeout. Bytes offered while rx_ready_o=0 are not consumed.
- Reset mid-load:
  - Next cycle all outputs take their reset values and any partial word is discarded.
  - ICCM words already written are not reverted.

Optional Feature:
ICCM_LOADER_CSUM_EN.
- Defined:
  - After the last WRITE, state CSUM accepts one more byte.
  - That byte must equal the XOR of all data bytes, otherwise the load goes to ERR.
  - core_rst_no is released only on a match.
- Undefined: no CSUM state; after the last WRITE go directly to DONE.

Decomposition:
- iccm_loader_pkg holds:
  - state enum typedef (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR);
  - HDR_BYTES=2;
  - WE_ALL=4'hF.
- Sub-module iccm_word_packer:
  - byte counter plus 32-bit little-endian shift assembly;
  - emits word_valid on the 4th byte;
  - clears on rst_i or start.

Test Plan:
- Zero length: reset, start_i, bytes 00 00 -> DONE the cycle after the 2nd transfer, no cycle with mem_en_o=1, core_rst_no=1, words_o=0.
- Two-word load: bytes 02 00 13 00 00 00 93 00 10 00 -> writes addr 0 = 32'h00000013, then addr 1 = 32'h00100093, mem_we_o=4'hF, done_o=1 and core_rst_no=1 the cycle after the 2nd write.
- Stalls: same stream with rx_valid_i low for 3 cycles between every byte -> identical writes; rx_ready_o=0 in every WRITE cycle.
- Oversize: ADDR_W=8, header 01 01 (257) -> err_o=1, no writes, core_rst_no stays 0; a following start_i clears err_o.
- Reset mid-load: header 01 00, then 2 data bytes, then rst_i=1 for one cycle -> reset values. Restart with 01 00 EF BE AD DE -> addr 0 = 32'hDEADBEEF.
- Checksum, ICCM_LOADER_CSUM_EN defined: 01 00 01 02 04 08 0F -> done_o=1; last byte 0E instead -> err_o=1, core_rst_no=0.
